axis_csum_ctrl: RTL and testbench

- Per-packet sequencer that drives the header-checksum offload stage.
- Accepts checksum descriptors (enable, start bit, offset bit) on a valid/ready queue and aligns each one with the first beat of the next AXI-Stream packet.
- Presents csum_enable/csum_start/csum_offset to the checksum stage on the beat it samples; forces csum_enable low on all other beats.
- Sits between the action pipeline parser and the checksum stage; the stream passes through with zero latency and backpressure gating only.

---
 rtl/axis_csum_ctrl_pkg.sv | 18 +
 rtl/axis_csum_ctrl_if.sv | 22 ++
 rtl/axis_csum_ctrl_desc_fifo.sv | 45 ++++
 rtl/axis_csum_ctrl.sv | 117 +++++++++++
 tb/tb_axis_csum_ctrl.sv | 540 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_csum_ctrl_pkg.sv
// Shared constants for the checksum offload sequencer: field widths,
// FSM state encodings and descriptor packing helpers.
package axis_csum_ctrl_pkg;

   localparam int CSUM_WIDTH          = 16;
   localparam int CSUM_DATA_WIDTH_DEF = 160;

   typedef logic [0:0] state_t;

   localparam state_t ST_SOP = 1'b0;
   localparam state_t ST_PKT = 1'b1;

   // Descriptors are packed as {enable, start, offset}.
   function automatic int desc_width(input int cl_width);
      return 1 + 2 * cl_width;
   endfunction

endpackage

// File: rtl/axis_csum_ctrl_if.sv
// AXI-Stream bundle used on both sides of the checksum sequencer.
interface axis_csum_ctrl_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
                   input  tready);
   modport slave  (input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
                   output tready);
endinterface

// File: rtl/axis_csum_ctrl_desc_fifo.sv
// Checksum descriptor queue: head is visible combinationally and reads as
// zero while empty so downstream fields sit at a known value.
module axis_csum_desc_fifo
   import axis_csum_ctrl_pkg::*;
#(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int           AW      = $clog2(DEPTH);
   localparam logic [AW:0]  PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Write-when-full is only issued alongside a pop, so the slot being
   // overwritten is the head that retires on this same edge.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/axis_csum_ctrl.sv
// Per-packet sequencer aligning queued checksum descriptors with the first
// beat of each AXI-Stream packet heading into the checksum stage.
//
//   state  | meaning
//   SOP    | waiting for first beat; stream gated until a descriptor is queued
//   PKT    | mid-packet pass-through; descriptor retires on accepted tlast
module axis_csum_ctrl
   import axis_csum_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH      = 512,
   parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
   parameter int ID_WIDTH        = 8,
   parameter int DEST_WIDTH      = 4,
   parameter int USER_WIDTH      = 4,
   parameter int CSUM_DATA_WIDTH = CSUM_DATA_WIDTH_DEF,
   parameter int DESC_DEPTH      = 4,
   parameter int CL_DATA_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_desc_valid,
   output logic                     s_desc_ready,
   input  logic                     s_desc_enable,
   input  logic [CL_DATA_WIDTH-1:0] s_desc_start,
   input  logic [CL_DATA_WIDTH-1:0] s_desc_offset,
   axis_csum_ctrl_if.slave          s_axis,
   axis_csum_ctrl_if.master         m_axis,
   output logic                     csum_enable,
   output logic [CL_DATA_WIDTH-1:0] csum_start,
   output logic [CL_DATA_WIDTH-1:0] csum_offset,
   output logic [31:0]              stat_pkt_count,
   output logic [31:0]              stat_csum_count,
   output logic [31:0]              stat_err_count
);
   localparam int DW = desc_width(CL_DATA_WIDTH);
   localparam int SW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

   localparam logic [CL_DATA_WIDTH:0] DATA_LIM  = (CL_DATA_WIDTH+1)'(DATA_WIDTH);
   localparam logic [CL_DATA_WIDTH:0] HDR_BITS  = (CL_DATA_WIDTH+1)'(CSUM_DATA_WIDTH);
   localparam logic [CL_DATA_WIDTH:0] FLD_BITS  = (CL_DATA_WIDTH+1)'(CSUM_WIDTH);

   logic [DW-1:0]            head;
   logic                     head_en;
   logic [CL_DATA_WIDTH-1:0] head_start;
   logic [CL_DATA_WIDTH-1:0] head_offset;
   logic                     head_ok;
   logic                     full;
   logic                     empty;
   logic                     push;
   logic                     pop;
   logic                     beat;
   state_t                   state;
   logic [SW-1:0]            side;

   assign side = {s_axis.tdata, s_axis.tkeep, s_axis.tid, s_axis.tdest, s_axis.tuser, s_axis.tlast};
   assign {m_axis.tdata, m_axis.tkeep, m_axis.tid, m_axis.tdest, m_axis.tuser, m_axis.tlast} = side;

   assign {head_en, head_start, head_offset} = head;

   assign head_ok = ({1'b0, head_start}  + HDR_BITS <= DATA_LIM) &&
                    ({1'b0, head_offset} + FLD_BITS <= DATA_LIM) &&
                    (head_start[2:0] == 3'b000) && (head_offset[2:0] == 3'b000);

   always_comb begin
      m_axis.tvalid = s_axis.tvalid;
      s_axis.tready = m_axis.tready;
      csum_enable   = 1'b0;
      if (state == ST_SOP) begin
         m_axis.tvalid = s_axis.tvalid && !empty;
         s_axis.tready = m_axis.tready && !empty;
         csum_enable   = head_en && head_ok;
      end
   end

   assign csum_start  = head_start;
   assign csum_offset = head_offset;

   assign beat = m_axis.tvalid && m_axis.tready;
   assign pop  = beat && s_axis.tlast;

   // Held low through reset without waiting for a clock edge.
   assign s_desc_ready = rst_n && (!full || pop);
   assign push         = s_desc_valid && s_desc_ready;

   axis_csum_desc_fifo #(
      .WIDTH (DW),
      .DEPTH (DESC_DEPTH)
   ) u_desc_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({s_desc_enable, s_desc_start, s_desc_offset}),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_SOP;
         stat_pkt_count  <= '0;
         stat_csum_count <= '0;
         stat_err_count  <= '0;
      end else if (beat) begin
         if (state == ST_SOP) begin
            stat_pkt_count <= stat_pkt_count + 32'd1;
            if (csum_enable)         stat_csum_count <= stat_csum_count + 32'd1;
            if (head_en && !head_ok) stat_err_count  <= stat_err_count + 32'd1;
            if (!s_axis.tlast)       state           <= ST_PKT;
         end else if (s_axis.tlast) begin
            state <= ST_SOP;
         end
      end
   end

endmodule

// File: tb/tb_axis_csum_ctrl.sv
// Self-checking bench for axis_csum_ctrl: directed scenarios plus randomized
// packets scored against a descriptor-queue reference model.
`timescale 1ns/1ps
module tb_axis_csum_ctrl;
   localparam int DW  = 512;
   localparam int KW  = 64;
   localparam int IW  = 8;
   localparam int DSW = 4;
   localparam int UW  = 4;
   localparam int CL  = 9;

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [KW-1:0]  keep;
      logic           last;
      logic [IW-1:0]  id;
      logic [DSW-1:0] dest;
      logic [UW-1:0]  user;
      logic           cen;
      logic [CL-1:0]  cs;
      logic [CL-1:0]  co;
   } beat_t;

   typedef struct packed {
      logic          en;
      logic [CL-1:0] st;
      logic [CL-1:0] of;
   } desc_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic          desc_en = 1'b0;
   logic [CL-1:0] desc_start = '0;
   logic [CL-1:0] desc_off = '0;
   logic          csum_en;
   logic [CL-1:0] csum_start;
   logic [CL-1:0] csum_off;
   logic [31:0]   st_pkt;
   logic [31:0]   st_csum;
   logic [31:0]   st_err;

   always #5 clk = ~clk;

   axis_csum_ctrl_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) s_if ();
   axis_csum_ctrl_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) m_if ();

   axis_csum_ctrl #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW),
      .CSUM_DATA_WIDTH(160), .DESC_DEPTH(4), .CL_DATA_WIDTH(CL)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_desc_valid    (desc_valid),
      .s_desc_ready    (desc_ready),
      .s_desc_enable   (desc_en),
      .s_desc_start    (desc_start),
      .s_desc_offset   (desc_off),
      .s_axis          (s_if),
      .m_axis          (m_if),
      .csum_enable     (csum_en),
      .csum_start      (csum_start),
      .csum_offset     (csum_off),
      .stat_pkt_count  (st_pkt),
      .stat_csum_count (st_csum),
      .stat_err_count  (st_err)
   );

   int    vectors = 0;
   int    miscompares = 0;
   beat_t obs[$];
   beat_t expq[$];
   desc_t dq[$];
   int    exp_pkt = 0;
   int    exp_csum = 0;
   int    exp_err = 0;
   beat_t mon_b;

   always @(negedge clk) begin
      if (rst_n && m_if.tvalid && m_if.tready) begin
         mon_b = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser,
                  csum_en, csum_start, csum_off};
         obs.push_back(mon_b);
      end
   end

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Checksum-stage window rule written as plain integer arithmetic.
   function automatic bit desc_ok(input int st, input int of);
      return (st + 160 <= 512) && (of + 16 <= 512) && (st % 8 == 0) && (of % 8 == 0);
   endfunction

   function automatic desc_t rand_desc();
      desc_t d;
      d.en = ($urandom_range(0, 3) != 0);
      d.st = ($urandom_range(0, 1) != 0) ? CL'($urandom_range(0, 44) * 8) : CL'($urandom);
      d.of = ($urandom_range(0, 1) != 0) ? CL'($urandom_range(0, 62) * 8) : CL'($urandom);
      return d;
   endfunction

   function automatic beat_t rand_beat(input bit last, input bit cen, input desc_t d);
      beat_t e;
      e.data = rand_data();
      e.keep = {$urandom, $urandom};
      e.last = last;
      e.id   = IW'($urandom);
      e.dest = DSW'($urandom);
      e.user = UW'($urandom);
      e.cen  = cen;
      e.cs   = d.st;
      e.co   = d.of;
      return e;
   endfunction

   task automatic drive_beat(input beat_t e);
      s_if.tdata  = e.data;
      s_if.tkeep  = e.keep;
      s_if.tlast  = e.last;
      s_if.tid    = e.id;
      s_if.tdest  = e.dest;
      s_if.tuser  = e.user;
      s_if.tvalid = 1'b1;
   endtask

   task automatic push_desc(input desc_t d);
      int n;
      n = 0;
      desc_valid = 1'b1;
      desc_en    = d.en;
      desc_start = d.st;
      desc_off   = d.of;
      @(negedge clk);
      while (desc_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL push_desc_timeout ready=%b required 1", desc_ready);
      end else begin
         dq.push_back(d);
      end
      @(posedge clk); #1;
      desc_valid = 1'b0;
   endtask

   // mode 0: tready always high, 1: random, 2: alternating 1010...
   task automatic send_pkt(input int nbeats, input int mode);
      desc_t d;
      beat_t e;
      bit    ok;
      bit    acc;
      int    cyc;
      if (dq.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL send_pkt_no_desc queued=0 required >0");
         return;
      end
      d  = dq.pop_front();
      ok = d.en && desc_ok(int'(d.st), int'(d.of));
      exp_pkt++;
      if (ok) exp_csum++;
      if (d.en && !ok) exp_err++;
      cyc = 0;
      for (int b = 0; b < nbeats; b++) begin
         e = rand_beat(b == nbeats - 1, ok && (b == 0), d);
         expq.push_back(e);
         drive_beat(e);
         acc = 1'b0;
         while (!acc && cyc < 200) begin
            case (mode)
               0:       m_if.tready = 1'b1;
               1:       m_if.tready = ($urandom_range(0, 1) != 0);
               default: m_if.tready = (cyc % 2 == 0);
            endcase
            cyc++;
            @(negedge clk);
            acc = (s_if.tready === 1'b1);
            @(posedge clk); #1;
         end
         if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_pkt_timeout beat=%0d tready=%b required 1", b, s_if.tready);
            s_if.tvalid = 1'b0;
            return;
         end
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (desc_ready !== 1'b0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 ||
          csum_en !== 1'b0 || csum_start !== '0 || csum_off !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs ready=%b tvalid=%b tready=%b cen=%b cs=%0d co=%0d required all 0",
                  desc_ready, m_if.tvalid, s_if.tready, csum_en, csum_start, csum_off);
      end
      vectors++;
      if (st_pkt !== 0 || st_csum !== 0 || st_err !== 0) begin
         miscompares++;
         $display("FAIL reset_counters pkt=%0d csum=%0d err=%0d required 0 0 0", st_pkt, st_csum, st_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (desc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready ready=%b required 1", desc_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      obs.delete(); expq.delete();
      push_desc('{en: 1'b1, st: 9'd112, of: 9'd192});
      send_pkt(2, 0);
      vectors++;
      if (obs.size() != 2) begin
         miscompares++;
         $display("FAIL basic_beats got=%0d required 2", obs.size());
      end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         vectors++;
         if (obs[i] !== expq[i]) begin
            miscompares++;
            $display("FAIL basic_beat%0d cen=%b cs=%0d co=%0d last=%b d=%h required cen=%b cs=%0d co=%0d last=%b d=%h",
                     i, obs[i].cen, obs[i].cs, obs[i].co, obs[i].last, obs[i].data[31:0],
                     expq[i].cen, expq[i].cs, expq[i].co, expq[i].last, expq[i].data[31:0]);
         end
      end
      vectors++;
      if (st_pkt !== 32'd1 || st_csum !== 32'd1 || st_err !== 32'd0) begin
         miscompares++;
         $display("FAIL basic_stats pkt=%0d csum=%0d err=%0d required 1 1 0", st_pkt, st_csum, st_err);
      end
   endtask

   task automatic test_empty_wait();
      beat_t e;
      desc_t d;
      obs.delete(); expq.delete();
      d = '{en: 1'b1, st: 9'd0, of: 9'd144};
      e = rand_beat(1'b1, 1'b1, d);
      expq.push_back(e);
      m_if.tready = 1'b1;
      drive_beat(e);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_wait_gate cycle=%0d tready=%b tvalid=%b required 0 0", c, s_if.tready, m_if.tvalid);
         end
         @(posedge clk); #1;
      end
      desc_valid = 1'b1; desc_en = d.en; desc_start = d.st; desc_off = d.of;
      @(negedge clk);
      vectors++;
      if (m_if.tvalid !== 1'b0 || desc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_wait_push_cycle tvalid=%b ready=%b required 0 1", m_if.tvalid, desc_ready);
      end
      @(posedge clk); #1;
      desc_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (m_if.tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_wait_forward tvalid=%b required 1", m_if.tvalid);
      end
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_pkt++; exp_csum++;
      vectors++;
      if (obs.size() != 1) begin
         miscompares++;
         $display("FAIL empty_wait_beats got=%0d required 1", obs.size());
      end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         vectors++;
         if (obs[i] !== expq[i]) begin
            miscompares++;
            $display("FAIL empty_wait_beat%0d cen=%b cs=%0d co=%0d d=%h required cen=%b cs=%0d co=%0d d=%h",
                     i, obs[i].cen, obs[i].cs, obs[i].co, obs[i].data[31:0],
                     expq[i].cen, expq[i].cs, expq[i].co, expq[i].data[31:0]);
         end
      end
      vectors++;
      if (st_pkt !== exp_pkt || st_csum !== exp_csum || st_err !== exp_err) begin
         miscompares++;
         $display("FAIL empty_wait_stats pkt=%0d csum=%0d err=%0d required %0d %0d %0d",
                  st_pkt, st_csum, st_err, exp_pkt, exp_csum, exp_err);
      end
   endtask

   task automatic test_range();
      obs.delete(); expq.delete();
      push_desc('{en: 1'b1, st: 9'd400, of: 9'd192});
      send_pkt(3, 0);
      push_desc('{en: 1'b1, st: 9'd112, of: 9'd193});
      send_pkt(2, 0);
      push_desc('{en: 1'b1, st: 9'd352, of: 9'd496});
      send_pkt(1, 0);
      vectors++;
      if (obs.size() != 6) begin
         miscompares++;
         $display("FAIL range_beats got=%0d required 6", obs.size());
      end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         vectors++;
         if (obs[i] !== expq[i]) begin
            miscompares++;
            $display("FAIL range_beat%0d cen=%b cs=%0d co=%0d last=%b d=%h required cen=%b cs=%0d co=%0d last=%b d=%h",
                     i, obs[i].cen, obs[i].cs, obs[i].co, obs[i].last, obs[i].data[31:0],
                     expq[i].cen, expq[i].cs, expq[i].co, expq[i].last, expq[i].data[31:0]);
         end
      end
      vectors++;
      if (st_pkt !== exp_pkt || st_csum !== exp_csum || st_err !== exp_err) begin
         miscompares++;
         $display("FAIL range_stats pkt=%0d csum=%0d err=%0d required %0d %0d %0d",
                  st_pkt, st_csum, st_err, exp_pkt, exp_csum, exp_err);
      end
   endtask

   task automatic test_backpressure();
      obs.delete(); expq.delete();
      push_desc('{en: 1'b1, st: 9'd112, of: 9'd192});
      push_desc('{en: 1'b1, st: 9'd0, of: 9'd496});
      send_pkt(3, 2);
      send_pkt(2, 1);
      vectors++;
      if (obs.size() != 5) begin
         miscompares++;
         $display("FAIL backpressure_beats got=%0d required 5", obs.size());
      end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         vectors++;
         if (obs[i] !== expq[i]) begin
            miscompares++;
            $display("FAIL backpressure_beat%0d cen=%b cs=%0d co=%0d last=%b d=%h required cen=%b cs=%0d co=%0d last=%b d=%h",
                     i, obs[i].cen, obs[i].cs, obs[i].co, obs[i].last, obs[i].data[31:0],
                     expq[i].cen, expq[i].cs, expq[i].co, expq[i].last, expq[i].data[31:0]);
         end
      end
   endtask

   task automatic test_full();
      desc_t d;
      desc_t h;
      beat_t e;
      bit    ok;
      obs.delete(); expq.delete();
      for (int k = 0; k < 4; k++) push_desc(rand_desc());
      @(negedge clk);
      vectors++;
      if (desc_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_ready ready=%b required 0", desc_ready);
      end
      @(posedge clk); #1;
      m_if.tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d = rand_desc();
         h = dq.pop_front();
         dq.push_back(d);
         ok = h.en && desc_ok(int'(h.st), int'(h.of));
         exp_pkt++;
         if (ok) exp_csum++;
         if (h.en && !ok) exp_err++;
         e = rand_beat(1'b1, ok, h);
         expq.push_back(e);
         drive_beat(e);
         desc_valid = 1'b1; desc_en = d.en; desc_start = d.st; desc_off = d.of;
         @(negedge clk);
         vectors++;
         if (desc_ready !== 1'b1 || m_if.tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_swap%0d ready=%b tvalid=%b required 1 1", k, desc_ready, m_if.tvalid);
         end
         @(posedge clk); #1;
      end
      desc_valid  = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      @(negedge clk);
      vectors++;
      if (desc_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_still_full ready=%b required 0", desc_ready);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) send_pkt($urandom_range(1, 3), 1);
      vectors++;
      if (obs.size() != expq.size()) begin
         miscompares++;
         $display("FAIL full_beats got=%0d required %0d", obs.size(), expq.size());
      end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         vectors++;
         if (obs[i] !== expq[i]) begin
            miscompares++;
            $display("FAIL full_beat%0d cen=%b cs=%0d co=%0d last=%b d=%h required cen=%b cs=%0d co=%0d last=%b d=%h",
                     i, obs[i].cen, obs[i].cs, obs[i].co, obs[i].last, obs[i].data[31:0],
                     expq[i].cen, expq[i].cs, expq[i].co, expq[i].last, expq[i].data[31:0]);
         end
      end
      vectors++;
      if (st_pkt !== exp_pkt || st_csum !== exp_csum || st_err !== exp_err) begin
         miscompares++;
         $display("FAIL full_stats pkt=%0d csum=%0d err=%0d required %0d %0d %0d",
                  st_pkt, st_csum, st_err, exp_pkt, exp_csum, exp_err);
      end
   endtask

   task automatic test_random();
      int n;
      obs.delete(); expq.delete();
      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) push_desc(rand_desc());
         for (int k = 0; k < n; k++) send_pkt($urandom_range(1, 5), $urandom_range(0, 1));
      end
      vectors++;
      if (obs.size() != expq.size()) begin
         miscompares++;
         $display("FAIL random_beats got=%0d required %0d", obs.size(), expq.size());
      end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
         vectors++;
         if (obs[i] !== expq[i]) begin
            miscompares++;
            $display("FAIL random_beat%0d cen=%b cs=%0d co=%0d last=%b d=%h required cen=%b cs=%0d co=%0d last=%b d=%h",
                     i, obs[i].cen, obs[i].cs, obs[i].co, obs[i].last, obs[i].data[31:0],
                     expq[i].cen, expq[i].cs, expq[i].co, expq[i].last, expq[i].data[31:0]);
         end
      end
      vectors++;
      if (st_pkt !== exp_pkt || st_csum !== exp_csum || st_err !== exp_err) begin
         miscompares++;
         $display("FAIL random_stats pkt=%0d csum=%0d err=%0d required %0d %0d %0d",
                  st_pkt, st_csum, st_err, exp_pkt, exp_csum, exp_err);
      end
   endtask

   task automatic test_reset_mid();
      desc_t d;
      push_desc('{en: 1'b1, st: 9'd112, of: 9'd192});
      push_desc('{en: 1'b1, st: 9'd0, of: 9'd144});
      d = dq[0];
      m_if.tready = 1'b1;
      drive_beat(rand_beat(1'b0, 1'b1, d));
      @(negedge clk);
      @(posedge clk); #1;
      drive_beat(rand_beat(1'b0, 1'b0, d));
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (desc_ready !== 1'b0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 ||
          csum_en !== 1'b0 || csum_start !== '0 || csum_off !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs ready=%b tvalid=%b tready=%b cen=%b cs=%0d co=%0d required all 0",
                  desc_ready, m_if.tvalid, s_if.tready, csum_en, csum_start, csum_off);
      end
      vectors++;
      if (st_pkt !== 0 || st_csum !== 0 || st_err !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_counters pkt=%0d csum=%0d err=%0d required 0 0 0", st_pkt, st_csum, st_err);
      end
      dq.delete();
      exp_pkt = 0; exp_csum = 0; exp_err = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (desc_ready !== 1'b1 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_release ready=%b tvalid=%b tready=%b required 1 0 0",
                  desc_ready, m_if.tvalid, s_if.tready);
      end
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
      obs.delete(); expq.delete();
      push_desc('{en: 1'b1, st: 9'd112, of: 9'd192});
      send_pkt(1, 0);
      vectors++;
      if (obs.size() != 1 || (obs.size() == 1 && obs[0] !== expq[0])) begin
         miscompares++;
         $display("FAIL reset_mid_after beats=%0d cen=%b required 1 beat cen=1", obs.size(),
                  (obs.size() > 0) ? obs[0].cen : 1'bx);
      end
      vectors++;
      if (st_pkt !== 32'd1 || st_csum !== 32'd1 || st_err !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid_stats pkt=%0d csum=%0d err=%0d required 1 1 0", st_pkt, st_csum, st_err);
      end
   endtask

   initial begin
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tid    = '0;
      s_if.tdest  = '0;
      s_if.tuser  = '0;
      m_if.tready = 1'b0;
      test_reset();
      test_basic();
      test_empty_wait();
      test_range();
      test_backpressure();
      test_full();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
